// File: rtl/pool_pkg.sv
// Shared types and constants for the global average pooling sequencer.
// Holds the FSM state encoding and the accumulator width helper.
package pool_pkg;

    localparam int POOL_LOG2_WIN = 6;
    localparam int POOL_DATA_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT,
        DONE
    } pool_state_t;

    // Full-width sum of 2**log2_win words of data_w bits never wraps.
    function automatic int acc_width(input int data_w, input int log2_win);
        return data_w + log2_win;
    endfunction

endpackage

// File: rtl/pool_acc.sv
// Wide running-sum accumulator for one pooling window.
// result_next is the floor average the register will hold after this edge.
module pool_acc
    import pool_pkg::*;
#(
    parameter int DATA_W   = POOL_DATA_W,
    parameter int LOG2_WIN = POOL_LOG2_WIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] result_next
);

    localparam int ACC_W = acc_width(DATA_W, LOG2_WIN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    // Clear wins over accumulate so a new channel never sees stale sums.
    always_comb begin
        acc_next = acc;
        if (clear) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc + ACC_W'(data_in);
        end
    end

    assign result_next = acc_next[ACC_W-1:LOG2_WIN];

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/pool_seq_ctrl.sv
// Global average pooling sequencer: streams each channel's window through
// one adder, divides by the window size and emits one result per channel.
module pool_seq_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_W   = POOL_DATA_W,
    parameter int LOG2_WIN = POOL_LOG2_WIN,
    parameter int NUM_CH   = 16,
    parameter int ADDR_W   = 12,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch
);

    localparam int OFF_W = CH_W + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] IDX_LAST = '1;
    localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NUM_CH - 1);

    pool_state_t         state;
    logic [ADDR_W-1:0]   base_q;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     ch_inc;
    logic [LOG2_WIN-1:0] idx;
    logic                rd_vld;
    logic                acc_clear;
    logic [DATA_W-1:0]   avg_next;
    logic [OFF_W-1:0]    next_off;
    logic                take;

    assign take   = (state == OUT) && out_ready;
    assign ch_inc = ch + CH_W'(1);

    // Offset of element 0 of the following channel.
    assign next_off = {ch_inc, {LOG2_WIN{1'b0}}};

    // Restart the sum on a new run and between channels.
    assign acc_clear = ((state == IDLE) && start) || take;

    pool_acc #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clear),
        .en          (rd_vld),
        .data_in     (mem_rd_data),
        .result_next (avg_next)
    );

    // Sequencer FSM with counters, address generation and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            ch        <= '0;
            idx       <= '0;
            rd_vld    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            rd_vld <= mem_rd_en;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        ch        <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= base_addr;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (idx == IDX_LAST) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        idx      <= idx + LOG2_WIN'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    out_valid <= 1'b1;
                    out_data  <= avg_next;
                    out_ch    <= ch;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ch == CH_LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ch        <= ch_inc;
                            idx       <= '0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_q + ADDR_W'(next_off);
                            state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl with a read-data model and scoreboards.
// Two instances: a single-channel run and a two-channel run.
module tb_pool_seq_ctrl;

    typedef struct {
        logic [15:0] d;
        int          ch;
    } exp_t;

    logic clk;
    int   cyc;
    int   checks;
    int   failures;
    int   mode;
    logic [11:0] cur_base;

    logic        a_rst, a_start, a_busy, a_done, a_rd_en;
    logic        a_out_valid, a_out_ready;
    logic [11:0] a_base, a_addr;
    logic [15:0] a_rd_data, a_out_data;
    logic [0:0]  a_out_ch;

    logic        b_rst, b_start, b_busy, b_done, b_rd_en;
    logic        b_out_valid, b_out_ready;
    logic [11:0] b_base, b_addr;
    logic [15:0] b_rd_data, b_out_data;
    logic [0:0]  b_out_ch;

    exp_t        a_q[$];
    exp_t        b_q[$];
    logic [11:0] a_aq[$];
    logic [11:0] b_aq[$];
    int          a_done_n;
    int          b_done_n;

    pool_seq_ctrl #(
        .DATA_W(16), .LOG2_WIN(6), .NUM_CH(1), .ADDR_W(12)
    ) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .base_addr(a_base),
        .busy(a_busy), .done(a_done), .mem_rd_en(a_rd_en),
        .mem_addr(a_addr), .mem_rd_data(a_rd_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ch(a_out_ch)
    );

    pool_seq_ctrl #(
        .DATA_W(16), .LOG2_WIN(6), .NUM_CH(2), .ADDR_W(12)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .base_addr(b_base),
        .busy(b_busy), .done(b_done), .mem_rd_en(b_rd_en),
        .mem_addr(b_addr), .mem_rd_data(b_rd_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ch(b_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(input int m, input logic [11:0] ad,
                                        input logic [11:0] b);
        logic [11:0] d;
        d = ad - b;
        case (m)
            0: return 16'd1;
            1: return {10'd0, d[5:0]};
            2: return 16'hFFFF;
            default: return 16'(int'(ad) * 37) ^ 16'h5A5A;
        endcase
    endfunction

    function automatic logic [15:0] exp_avg(input int m, input logic [11:0] b,
                                            input int c);
        int sum;
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            sum += int'(pat(m, 12'(int'(b) + c * 64 + i), b));
        end
        return 16'(sum / 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer model: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? pat(mode, a_addr, cur_base) : 16'hDEAD;
        b_rd_data <= b_rd_en ? pat(mode, b_addr, cur_base) : 16'hDEAD;
    end

    // Address and result scoreboards.
    always @(negedge clk) begin
        if (a_done) a_done_n++;
        if (b_done) b_done_n++;
        if (a_rd_en) begin
            chk("a_rd_expected", a_aq.size() != 0, 1);
            if (a_aq.size() != 0) chk("a_addr", a_addr, a_aq.pop_front());
        end
        if (b_rd_en) begin
            chk("b_rd_expected", b_aq.size() != 0, 1);
            if (b_aq.size() != 0) chk("b_addr", b_addr, b_aq.pop_front());
        end
        if (a_out_valid && a_out_ready) begin
            chk("a_out_expected", a_q.size() != 0, 1);
            if (a_q.size() != 0) begin
                exp_t e;
                e = a_q.pop_front();
                chk("a_out_data", a_out_data, e.d);
                chk("a_out_ch", a_out_ch, e.ch);
            end
        end
        if (b_out_valid && b_out_ready) begin
            chk("b_out_expected", b_q.size() != 0, 1);
            if (b_q.size() != 0) begin
                exp_t e;
                e = b_q.pop_front();
                chk("b_out_data", b_out_data, e.d);
                chk("b_out_ch", b_out_ch, e.ch);
            end
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return a_rd_en;
            1: return a_out_valid;
            2: return a_done;
            3: return b_out_valid;
            4: return b_done;
            default: return b_rd_en;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int w, input int bound);
        int n;
        n = 0;
        while (!sel(w) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sel(w), 1);
    endtask

    task automatic start_run(input bit use_b, input logic [11:0] b,
                             input int m);
        int nch;
        nch = use_b ? 2 : 1;
        cur_base = b;
        mode = m;
        for (int c = 0; c < nch; c++) begin
            exp_t e;
            e.d = exp_avg(m, b, c);
            e.ch = c;
            if (use_b) b_q.push_back(e);
            else a_q.push_back(e);
            for (int i = 0; i < 64; i++) begin
                if (use_b) b_aq.push_back(12'(int'(b) + c * 64 + i));
                else a_aq.push_back(12'(int'(b) + c * 64 + i));
            end
        end
        @(posedge clk);
        #1;
        if (use_b) begin
            b_base = b;
            b_start = 1'b1;
        end else begin
            a_base = b;
            a_start = 1'b1;
        end
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic run_a(input string tag, input logic [11:0] b, input int m);
        int d0;
        d0 = a_done_n;
        start_run(1'b0, b, m);
        wait_sig({tag, "_done_seen"}, 2, 300);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, a_done_n - d0, 1);
        chk({tag, "_out_left"}, a_q.size(), 0);
        chk({tag, "_addr_left"}, a_aq.size(), 0);
    endtask

    initial begin
        int t0;
        int d0;
        logic [15:0] hd;
        logic [0:0]  hc;
        checks = 0;
        failures = 0;
        a_done_n = 0;
        b_done_n = 0;
        mode = 0;
        cur_base = '0;
        a_rst = 1'b1; a_start = 1'b0; a_base = '0; a_out_ready = 1'b1;
        b_rst = 1'b1; b_start = 1'b0; b_base = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_rd_en", a_rd_en, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_a_ch", a_out_ch, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_rd_en", b_rd_en, 0);

        // Single channel of ones: latency and result.
        d0 = a_done_n;
        start_run(1'b0, 12'h020, 0);
        wait_sig("t1_first_rd", 0, 10);
        t0 = cyc;
        chk("t1_busy", a_busy, 1);
        wait_sig("t1_valid_seen", 1, 100);
        chk("t1_latency", cyc - t0, 65);
        wait_sig("t1_done_seen", 2, 10);
        repeat (3) @(negedge clk);
        chk("t1_done_pulses", a_done_n - d0, 1);
        chk("t1_busy_after", a_busy, 0);
        chk("t1_out_left", a_q.size(), 0);
        chk("t1_addr_left", a_aq.size(), 0);

        // Ramp and full-scale windows.
        run_a("t2_ramp", 12'h040, 1);
        run_a("t2_max", 12'h0C0, 2);

        // Two channels from 0x100.
        d0 = b_done_n;
        start_run(1'b1, 12'h100, 3);
        wait_sig("t3_done_seen", 4, 300);
        repeat (3) @(negedge clk);
        chk("t3_done_pulses", b_done_n - d0, 1);
        chk("t3_out_left", b_q.size(), 0);
        chk("t3_addr_left", b_aq.size(), 0);

        // Backpressure for 5 cycles on channel 0.
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        d0 = b_done_n;
        start_run(1'b1, 12'h200, 1);
        wait_sig("t4_valid_seen", 3, 100);
        hd = b_out_data;
        hc = b_out_ch;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_valid", b_out_valid, 1);
            chk("t4_hold_data", b_out_data, hd);
            chk("t4_hold_ch", b_out_ch, hc);
            chk("t4_hold_no_rd", b_rd_en, 0);
        end
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_resume_rd", b_rd_en, 1);
        chk("t4_resume_valid", b_out_valid, 0);
        wait_sig("t4_done_seen", 4, 200);
        repeat (3) @(negedge clk);
        chk("t4_done_pulses", b_done_n - d0, 1);
        chk("t4_out_left", b_q.size(), 0);

        // Start during FETCH and on the DONE cycle is ignored.
        d0 = a_done_n;
        start_run(1'b0, 12'h300, 2);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        wait_sig("t5_done_seen", 2, 200);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        repeat (150) @(negedge clk);
        chk("t5_done_pulses", a_done_n - d0, 1);
        chk("t5_busy", a_busy, 0);
        chk("t5_out_left", a_q.size(), 0);
        chk("t5_addr_left", a_aq.size(), 0);

        // Reset mid-window, then a clean rerun.
        d0 = a_done_n;
        start_run(1'b0, 12'h080, 3);
        repeat (30) @(posedge clk);
        #1;
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_rd_en", a_rd_en, 0);
        chk("t6_rst_addr", a_addr, 0);
        chk("t6_rst_valid", a_out_valid, 0);
        chk("t6_rst_data", a_out_data, 0);
        chk("t6_rst_done", a_done, 0);
        a_q.delete();
        a_aq.delete();
        repeat (80) @(negedge clk);
        chk("t6_no_done", a_done_n - d0, 0);
        chk("t6_idle_valid", a_out_valid, 0);
        run_a("t6_rerun", 12'h080, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
